// File: rtl/l1d_id_pkg.sv
`default_nettype none
// ============================================================================
// l1d_id_pkg : shared constants, table entry type and helpers for the
//              L1D transaction-ID tracker.
// Rev 1.0
// ============================================================================
package l1d_id_pkg;

    localparam int unsigned ID_NUM   = 8;
    localparam int unsigned ID_W     = $clog2(ID_NUM);
    localparam int unsigned META_W   = 40;
    localparam int unsigned TO_W     = 10;
    localparam int unsigned TO_LIMIT = 1000;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_RSP_IDLE = 2'd1;
    localparam logic [1:0] ERR_CXL      = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef struct packed {
        logic              busy;
        logic              to_flag;
        logic [TO_W-1:0]   timer;
        logic [META_W-1:0] meta;
    } entry_t;

    function automatic logic [ID_W:0] popcount(input logic [ID_NUM-1:0] v);
        logic [ID_W:0] n;
        n = '0;
        for (int i = 0; i < int'(ID_NUM); i++) begin
            n = n + {{ID_W{1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/l1d_id_rel_hold.sv
`default_nettype none
// ============================================================================
// l1d_id_rel_hold : one-entry holding register carrying a freed ID to the
//                   pool release port; refills in the cycle it drains.
// Rev 1.0
// ============================================================================
module l1d_id_rel_hold
    import l1d_id_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [ID_W-1:0] in_id,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [ID_W-1:0] out_id
);

    logic            full_q, full_d;
    logic [ID_W-1:0] id_q, id_d;

    assign in_rdy  = ~full_q | out_rdy;
    assign out_vld = full_q;
    assign out_id  = id_q;

    always_comb begin
        full_d = full_q;
        id_d   = id_q;
        if (full_q && out_rdy) begin
            full_d = 1'b0;
        end
        if (in_vld && in_rdy) begin
            full_d = 1'b1;
            id_d   = in_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            id_q   <= '0;
        end else begin
            full_q <= full_d;
            id_q   <= id_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/l1d_id_tracker.sv
`default_nettype none
// ============================================================================
// l1d_id_tracker : pairs requests with free IDs, tracks them until response
//                  or cancel, and returns them to the pool on two lanes.
// Rev 1.0
// ============================================================================
module l1d_id_tracker
    import l1d_id_pkg::*;
#(
    parameter int unsigned TO_LIMIT = l1d_id_pkg::TO_LIMIT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_vld,
    output logic                req_rdy,
    input  logic [META_W-1:0]   req_meta,
    input  logic                pool_vld,
    output logic                pool_rdy,
    input  logic [ID_W-1:0]     pool_id,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic [ID_W-1:0]     out_id,
    output logic [META_W-1:0]   out_meta,
    input  logic                rsp_vld,
    output logic                rsp_rdy,
    input  logic [ID_W-1:0]     rsp_id,
    output logic                ret_vld,
    output logic [ID_W-1:0]     ret_id,
    output logic [META_W-1:0]   ret_meta,
    input  logic                cxl_vld,
    output logic                cxl_rdy,
    input  logic [ID_W-1:0]     cxl_id,
    output logic [1:0]          rel_vld,
    input  logic [1:0]          rel_rdy,
    output logic [2*ID_W-1:0]   rel_id,
    output logic [ID_NUM-1:0]   busy_vec,
    output logic [ID_W:0]       busy_cnt,
    output logic                err_vld,
    output logic [1:0]          err_code,
    output logic [ID_W-1:0]     err_id
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TO_LIMIT);

    entry_t tbl_q [ID_NUM];
    entry_t tbl_d [ID_NUM];

    logic                out_vld_q, out_vld_d;
    logic [ID_W-1:0]     out_id_q, out_id_d;
    logic [META_W-1:0]   out_meta_q, out_meta_d;
    logic                ret_vld_q, ret_vld_d;
    logic [ID_W-1:0]     ret_id_q, ret_id_d;
    logic [META_W-1:0]   ret_meta_q, ret_meta_d;
    logic                err_vld_q, err_vld_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [ID_W-1:0]     err_id_q, err_id_d;
    logic [ID_W:0]       busy_cnt_q, busy_cnt_d;

    logic                acc;
    logic                rsp_acc, rsp_hit;
    logic                cxl_acc, cxl_hit;
    logic [ID_NUM-1:0]   to_cand;
    logic [ID_NUM-1:0]   busy_nxt;
    logic [ID_W-1:0]     to_idx;
    logic [1:0]          hold_in_vld;
    logic [1:0]          hold_in_rdy;
    logic [ID_W-1:0]     hold_in_id [2];

    assign acc      = req_vld & pool_vld & (~out_vld_q | out_rdy);
    assign req_rdy  = acc;
    assign pool_rdy = acc;
    assign rsp_rdy  = hold_in_rdy[0];
    assign cxl_rdy  = hold_in_rdy[1];

    // A cancel colliding with an accepted response to the same ID loses.
    assign rsp_acc = rsp_vld & rsp_rdy;
    assign rsp_hit = rsp_acc & tbl_q[rsp_id].busy;
    assign cxl_acc = cxl_vld & cxl_rdy;
    assign cxl_hit = cxl_acc & tbl_q[cxl_id].busy & ~(rsp_acc && (rsp_id == cxl_id));

    assign hold_in_vld   = {cxl_hit, rsp_hit};
    assign hold_in_id[0] = rsp_id;
    assign hold_in_id[1] = cxl_id;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        l1d_id_rel_hold u_hold (
            .clk     (clk),
            .rst_n   (rst_n),
            .in_vld  (hold_in_vld[g]),
            .in_rdy  (hold_in_rdy[g]),
            .in_id   (hold_in_id[g]),
            .out_vld (rel_vld[g]),
            .out_rdy (rel_rdy[g]),
            .out_id  (rel_id[g*ID_W +: ID_W])
        );
    end

    always_comb begin
        to_cand = '0;
        to_idx  = '0;
        for (int i = 0; i < int'(ID_NUM); i++) begin
            tbl_d[i] = tbl_q[i];
            if (tbl_q[i].busy) begin
                if (tbl_q[i].timer != TO_LIM) begin
                    tbl_d[i].timer = tbl_q[i].timer + TO_W'(1);
                end
                to_cand[i] = ~tbl_q[i].to_flag && (tbl_d[i].timer == TO_LIM)
                           && !(rsp_hit && (rsp_id == ID_W'(i)))
                           && !(cxl_hit && (cxl_id == ID_W'(i)));
            end
        end
        for (int i = int'(ID_NUM) - 1; i >= 0; i--) begin
            if (to_cand[i]) begin
                to_idx = ID_W'(i);
            end
        end

        err_vld_d  = 1'b0;
        err_code_d = ERR_NONE;
        err_id_d   = '0;
        // to_flag is set only when reported, so an outranked timeout re-fires.
        if (rsp_acc && !tbl_q[rsp_id].busy) begin
            err_vld_d  = 1'b1;
            err_code_d = ERR_RSP_IDLE;
            err_id_d   = rsp_id;
        end else if (cxl_acc && !cxl_hit) begin
            err_vld_d  = 1'b1;
            err_code_d = ERR_CXL;
            err_id_d   = cxl_id;
        end else if (|to_cand) begin
            err_vld_d  = 1'b1;
            err_code_d = ERR_TIMEOUT;
            err_id_d   = to_idx;
            tbl_d[to_idx].to_flag = 1'b1;
        end

        if (rsp_hit) begin
            tbl_d[rsp_id].busy = 1'b0;
        end
        if (cxl_hit) begin
            tbl_d[cxl_id].busy = 1'b0;
        end
        if (acc) begin
            tbl_d[pool_id] = '{busy: 1'b1, to_flag: 1'b0, timer: '0, meta: req_meta};
        end

        ret_vld_d  = rsp_hit;
        ret_id_d   = rsp_hit ? rsp_id : '0;
        ret_meta_d = rsp_hit ? tbl_q[rsp_id].meta : '0;

        out_vld_d  = acc | (out_vld_q & ~out_rdy);
        out_id_d   = acc ? pool_id  : out_id_q;
        out_meta_d = acc ? req_meta : out_meta_q;
    end

    always_comb begin
        for (int i = 0; i < int'(ID_NUM); i++) begin
            busy_nxt[i] = tbl_d[i].busy;
            busy_vec[i] = tbl_q[i].busy;
        end
        busy_cnt_d = popcount(busy_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ID_NUM); i++) begin
                tbl_q[i] <= '0;
            end
            out_vld_q  <= 1'b0;
            out_id_q   <= '0;
            out_meta_q <= '0;
            ret_vld_q  <= 1'b0;
            ret_id_q   <= '0;
            ret_meta_q <= '0;
            err_vld_q  <= 1'b0;
            err_code_q <= ERR_NONE;
            err_id_q   <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(ID_NUM); i++) begin
                tbl_q[i] <= tbl_d[i];
            end
            out_vld_q  <= out_vld_d;
            out_id_q   <= out_id_d;
            out_meta_q <= out_meta_d;
            ret_vld_q  <= ret_vld_d;
            ret_id_q   <= ret_id_d;
            ret_meta_q <= ret_meta_d;
            err_vld_q  <= err_vld_d;
            err_code_q <= err_code_d;
            err_id_q   <= err_id_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_id   = out_id_q;
    assign out_meta = out_meta_q;
    assign ret_vld  = ret_vld_q;
    assign ret_id   = ret_id_q;
    assign ret_meta = ret_meta_q;
    assign err_vld  = err_vld_q;
    assign err_code = err_code_q;
    assign err_id   = err_id_q;
    assign busy_cnt = busy_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_l1d_id_tracker.sv
`default_nettype none
// ============================================================================
// tb_l1d_id_tracker : directed bench for l1d_id_tracker with a small free-ID
//                     pool model on the allocate / release ports.
// Rev 1.0
// ============================================================================
module tb_l1d_id_tracker;

    logic        clk;
    logic        rst_n;
    logic        req_vld;
    logic        req_rdy;
    logic [39:0] req_meta;
    logic        pool_vld;
    logic        pool_rdy;
    logic [2:0]  pool_id;
    logic        out_vld;
    logic        out_rdy;
    logic [2:0]  out_id;
    logic [39:0] out_meta;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [2:0]  rsp_id;
    logic        ret_vld;
    logic [2:0]  ret_id;
    logic [39:0] ret_meta;
    logic        cxl_vld;
    logic        cxl_rdy;
    logic [2:0]  cxl_id;
    logic [1:0]  rel_vld;
    logic [1:0]  rel_rdy;
    logic [5:0]  rel_id;
    logic [7:0]  busy_vec;
    logic [3:0]  busy_cnt;
    logic        err_vld;
    logic [1:0]  err_code;
    logic [2:0]  err_id;

    int n_checks = 0;
    int n_fail   = 0;

    l1d_id_tracker #(.TO_LIMIT(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_vld  (req_vld),
        .req_rdy  (req_rdy),
        .req_meta (req_meta),
        .pool_vld (pool_vld),
        .pool_rdy (pool_rdy),
        .pool_id  (pool_id),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_id   (out_id),
        .out_meta (out_meta),
        .rsp_vld  (rsp_vld),
        .rsp_rdy  (rsp_rdy),
        .rsp_id   (rsp_id),
        .ret_vld  (ret_vld),
        .ret_id   (ret_id),
        .ret_meta (ret_meta),
        .cxl_vld  (cxl_vld),
        .cxl_rdy  (cxl_rdy),
        .cxl_id   (cxl_id),
        .rel_vld  (rel_vld),
        .rel_rdy  (rel_rdy),
        .rel_id   (rel_id),
        .busy_vec (busy_vec),
        .busy_cnt (busy_cnt),
        .err_vld  (err_vld),
        .err_code (err_code),
        .err_id   (err_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-ID pool: resets holding 0..7, pops on pool_rdy, lane 0 pushed before lane 1.
    logic [2:0] pf [8];
    logic [2:0] rd_p, wr_p;
    logic [3:0] cnt;
    logic       push0, push1;
    logic [2:0] wr_p1;

    assign push0    = rel_vld[0] & rel_rdy[0];
    assign push1    = rel_vld[1] & rel_rdy[1];
    assign wr_p1    = wr_p + {2'b00, push0};
    assign pool_vld = (cnt != 4'd0);
    assign pool_id  = pf[rd_p];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) pf[i] <= 3'(i);
            rd_p <= 3'd0;
            wr_p <= 3'd0;
            cnt  <= 4'd8;
        end else begin
            if (push0) pf[wr_p]  <= rel_id[2:0];
            if (push1) pf[wr_p1] <= rel_id[5:3];
            if (pool_rdy) rd_p <= rd_p + 3'd1;
            wr_p <= wr_p + {2'b00, push0} + {2'b00, push1};
            cnt  <= cnt + {3'b000, push0} + {3'b000, push1} - {3'b000, pool_rdy};
        end
    end

    function automatic logic [39:0] meta_of(input int k);
        return 40'hC0_FFEE_0000 + 40'(k);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        req_vld  = 1'b0;
        req_meta = '0;
        out_rdy  = 1'b1;
        rsp_vld  = 1'b0;
        rsp_id   = '0;
        cxl_vld  = 1'b0;
        cxl_id   = '0;
        rel_rdy  = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_vld",  64'(out_vld),  64'd0);
        chk("rst_ret_vld",  64'(ret_vld),  64'd0);
        chk("rst_rel_vld",  64'(rel_vld),  64'd0);
        chk("rst_err_vld",  64'(err_vld),  64'd0);
        chk("rst_busy_cnt", 64'(busy_cnt), 64'd0);
        chk("rst_busy_vec", 64'(busy_vec), 64'd0);
        rst_n = 1'b1;

        // Eight back-to-back allocations take IDs 0..7.
        req_vld = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_meta = meta_of(k);
            #1;
            chk("alloc_req_rdy", 64'(req_rdy), 64'd1);
            tick();
            chk("alloc_out_vld",  64'(out_vld),  64'd1);
            chk("alloc_out_id",   64'(out_id),   64'(k));
            chk("alloc_out_meta", 64'(out_meta), 64'(meta_of(k)));
        end
        #1;
        chk("empty_req_rdy", 64'(req_rdy),  64'd0);
        chk("full_busy_cnt", 64'(busy_cnt), 64'd8);
        req_vld = 1'b0;

        // ID k was allocated at edge A0+k and must time out at edge A0+16+k.
        repeat (8) tick();
        chk("to_not_early", 64'(err_vld), 64'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("to_err_vld",  64'(err_vld),  64'd1);
            chk("to_err_code", 64'(err_code), 64'd3);
            chk("to_err_id",   64'(err_id),   64'(k));
        end
        tick();
        chk("to_once", 64'(err_vld), 64'd0);
        repeat (4) tick();
        chk("to_quiet",     64'(err_vld),  64'd0);
        chk("to_busy_kept", 64'(busy_cnt), 64'd8);

        // Retire ID 3 with lane 0 stalled for four cycles.
        rel_rdy = 2'b00;
        rsp_vld = 1'b1;
        rsp_id  = 3'd3;
        #1;
        chk("ret_rsp_rdy", 64'(rsp_rdy), 64'd1);
        tick();
        chk("ret_vld",      64'(ret_vld),     64'd1);
        chk("ret_id",       64'(ret_id),      64'd3);
        chk("ret_meta",     64'(ret_meta),    64'(meta_of(3)));
        chk("ret_rel_vld",  64'(rel_vld),     64'b01);
        chk("ret_rel_id",   64'(rel_id[2:0]), 64'd3);
        chk("ret_busy_cnt", 64'(busy_cnt),    64'd7);
        rsp_id = 3'd4;
        #1;
        chk("stall_rsp_rdy", 64'(rsp_rdy), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_rel_vld", 64'(rel_vld),     64'b01);
            chk("stall_rel_id",  64'(rel_id[2:0]), 64'd3);
            chk("stall_ret_vld", 64'(ret_vld),     64'd0);
            chk("stall_rsp_rdy", 64'(rsp_rdy),     64'd0);
        end
        rel_rdy = 2'b01;
        #1;
        chk("drain_rsp_rdy", 64'(rsp_rdy), 64'd1);
        tick();
        chk("drain_ret_id",  64'(ret_id),      64'd4);
        chk("drain_ret_vld", 64'(ret_vld),     64'd1);
        chk("reload_rel_id", 64'(rel_id[2:0]), 64'd4);
        chk("reload_rel",    64'(rel_vld),     64'b01);
        rsp_vld = 1'b0;
        rel_rdy = 2'b11;
        tick();
        chk("drained_rel_vld", 64'(rel_vld),  64'd0);
        chk("drained_busy",    64'(busy_vec), 64'b1110_0111);

        // Response on 2 and cancel on 5 release together.
        rsp_vld = 1'b1; rsp_id = 3'd2;
        cxl_vld = 1'b1; cxl_id = 3'd5;
        #1;
        chk("dual_cxl_rdy", 64'(cxl_rdy), 64'd1);
        tick();
        chk("dual_ret_id",   64'(ret_id),   64'd2);
        chk("dual_rel_vld",  64'(rel_vld),  64'b11);
        chk("dual_rel_id",   64'(rel_id),   64'b101_010);
        chk("dual_busy_cnt", 64'(busy_cnt), 64'd4);
        chk("dual_err_vld",  64'(err_vld),  64'd0);

        // Response and cancel both on 6: response wins, cancel flagged.
        rsp_id = 3'd6;
        cxl_id = 3'd6;
        tick();
        chk("same_ret_vld",  64'(ret_vld),     64'd1);
        chk("same_ret_id",   64'(ret_id),      64'd6);
        chk("same_err_code", 64'(err_code),    64'd2);
        chk("same_err_id",   64'(err_id),      64'd6);
        chk("same_rel_vld",  64'(rel_vld),     64'b01);
        chk("same_rel_id",   64'(rel_id[2:0]), 64'd6);
        chk("same_busy_cnt", 64'(busy_cnt),    64'd3);
        rsp_vld = 1'b0;
        cxl_vld = 1'b0;
        tick();
        chk("same_drained", 64'(rel_vld), 64'd0);

        // Response to idle ID 4, then cancel to idle ID 2.
        rsp_vld = 1'b1; rsp_id = 3'd4;
        tick();
        chk("idle_rsp_err_vld",  64'(err_vld),  64'd1);
        chk("idle_rsp_err_code", 64'(err_code), 64'd1);
        chk("idle_rsp_err_id",   64'(err_id),   64'd4);
        chk("idle_rsp_ret_vld",  64'(ret_vld),  64'd0);
        chk("idle_rsp_rel_vld",  64'(rel_vld),  64'd0);
        rsp_vld = 1'b0;
        cxl_vld = 1'b1; cxl_id = 3'd2;
        tick();
        chk("idle_cxl_err_code", 64'(err_code), 64'd2);
        chk("idle_cxl_err_id",   64'(err_id),   64'd2);
        chk("idle_cxl_rel_vld",  64'(rel_vld),  64'd0);
        chk("idle_busy_cnt",     64'(busy_cnt), 64'd3);
        cxl_vld = 1'b0;

        // Timed-out ID 1 still retires with its stored metadata.
        rsp_vld = 1'b1; rsp_id = 3'd1;
        tick();
        chk("late_ret_id",   64'(ret_id),   64'd1);
        chk("late_ret_meta", 64'(ret_meta), 64'(meta_of(1)));
        chk("late_err_vld",  64'(err_vld),  64'd0);
        chk("late_busy_cnt", 64'(busy_cnt), 64'd2);
        rsp_vld = 1'b0;
        tick();

        // Pool order is now 3,4,2,5,6,1; take four, then retire 7 with lane 0 stalled.
        req_vld = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_meta = 40'h11_0000_0000 + 40'(k);
            tick();
        end
        chk("realloc_last_id", 64'(out_id), 64'd5);
        req_vld = 1'b0;
        rel_rdy = 2'b00;
        rsp_vld = 1'b1; rsp_id = 3'd7;
        tick();
        chk("pre_rst_busy_cnt", 64'(busy_cnt), 64'd5);
        chk("pre_rst_rel_vld",  64'(rel_vld),  64'b01);
        chk("pre_rst_ret_vld",  64'(ret_vld),  64'd1);
        rsp_vld = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("mid_rst_ret_vld",  64'(ret_vld),  64'd0);
        chk("mid_rst_rel_vld",  64'(rel_vld),  64'd0);
        chk("mid_rst_out_vld",  64'(out_vld),  64'd0);
        chk("mid_rst_busy_cnt", 64'(busy_cnt), 64'd0);
        chk("mid_rst_busy_vec", 64'(busy_vec), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        rel_rdy = 2'b11;

        req_vld = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_meta = 40'h22_0000_0000 + 40'(k);
            #1;
            chk("post_rst_req_rdy", 64'(req_rdy), 64'd1);
            tick();
            chk("post_rst_out_id", 64'(out_id), 64'(k));
        end
        req_vld = 1'b0;
        chk("post_rst_busy_cnt", 64'(busy_cnt), 64'd8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
